muldiv_unit: RTL

Iterative RV32M multiply/divide unit for the execute stage of the RISC-V core. It sits beside the single-cycle ALU, takes the same A/B operand buses and the instruction's 3-bit funct, and returns a 32-bit result after a fixed multi-cycle latency. The unit uses a valid/ready handshake on both sides so the pipeline control can stall around it. MUL/DIV instructions are steered here instead of the ALU; the writeback mux selects Out when out_valid is high.

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 37 +++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M constants: funct3/funct7 encodings, FSM states and small helpers
// used by the decoder and the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned Width = 32;
  localparam logic [4:0]  IterLast = 5'd31;
  localparam logic [6:0]  Funct7MulDiv = 7'b0000001;

  typedef enum logic [2:0] {
    FnMul    = 3'b000,
    FnMulh   = 3'b001,
    FnMulhsu = 3'b010,
    FnMulhu  = 3'b011,
    FnDiv    = 3'b100,
    FnDivu   = 3'b101,
    FnRem    = 3'b110,
    FnRemu   = 3'b111
  } funct_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [Width-1:0] abs_val(input logic [Width-1:0] v, input logic is_signed);
    return (is_signed && v[Width-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
// hi/lo form the 64-bit product or the {remainder, quotient} pair.
module muldiv_iter
  import muldiv_unit_pkg::*;
(
  input  logic             div_i,
  input  logic [Width-1:0] hi_i,
  input  logic [Width-1:0] lo_i,
  input  logic [Width-1:0] opb_i,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  logic [Width:0] mul_sum;
  logic [Width:0] div_shift;
  logic [Width:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    div_shift = {hi_i, lo_i[Width-1]};
    div_diff  = div_shift - {1'b0, opb_i};
    if (div_i) begin
      // Remainder stays below the divisor, so bit 32 of the difference is the borrow.
      if (!div_diff[Width]) begin
        hi_o = div_diff[Width-1:0];
        lo_o = {lo_i[Width-2:0], 1'b1};
      end else begin
        hi_o = div_shift[Width-1:0];
        lo_o = {lo_i[Width-2:0], 1'b0};
      end
    end else begin
      hi_o = mul_sum[Width:1];
      lo_o = {mul_sum[0], lo_i[Width-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 iterations on operand magnitudes, sign fix-up
// and special-case overrides applied as the result is registered.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] Out
);

  state_e           state_q, state_d;
  funct_e           funct_q, funct_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;
  logic [Width-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;
  logic             divz_q, divz_d;
  logic             ovf_q, ovf_d;
  logic [Width-1:0] out_q, out_d;

  logic [Width-1:0]   hi_nxt, lo_nxt;
  logic [2*Width-1:0] prod_s;
  logic [Width-1:0]   quot_s, rem_s, result;
  logic               a_signed, b_signed, in_div;
  funct_e             in_funct;

  muldiv_iter u_iter (
    .div_i (funct_q[2]),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .opb_i (opb_q),
    .hi_o  (hi_nxt),
    .lo_o  (lo_nxt)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Out       = out_q;

  // Final result from the last iteration's outputs, so Out is valid on the first DONE cycle.
  always_comb begin
    prod_s = {hi_nxt, lo_nxt};
    if (neg_q) prod_s = ~prod_s + 1'b1;
    quot_s = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
    rem_s  = neg_q ? (~hi_nxt + 1'b1) : hi_nxt;
    case (funct_q)
      FnMul:                     result = prod_s[Width-1:0];
      FnMulh, FnMulhsu, FnMulhu: result = prod_s[2*Width-1:Width];
      FnDiv, FnDivu: begin
        if (divz_q)     result = '1;
        else if (ovf_q) result = 32'h8000_0000;
        else            result = quot_s;
      end
      // Divide-by-zero leaves |A| in the remainder with sign(A) latched, which yields A.
      default:          result = ovf_q ? '0 : rem_s;
    endcase
  end

  always_comb begin
    in_funct = funct_e'(funct);
    in_div   = funct[2];
    a_signed = (in_funct inside {FnMul, FnMulh, FnMulhsu, FnDiv, FnRem});
    b_signed = (in_funct inside {FnMul, FnMulh, FnDiv, FnRem});

    state_d = state_q;
    funct_d = funct_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    divz_d  = divz_q;
    ovf_d   = ovf_q;
    out_d   = out_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          funct_d = in_funct;
          cnt_d   = IterLast;
          hi_d    = '0;
          if (in_div) begin
            lo_d  = abs_val(A, a_signed);
            opb_d = abs_val(B, b_signed);
          end else begin
            lo_d  = abs_val(B, b_signed);
            opb_d = abs_val(A, a_signed);
          end
          case (in_funct)
            FnDiv:   neg_d = A[Width-1] ^ B[Width-1];
            FnRem:   neg_d = A[Width-1];
            FnDivu,
            FnRemu:  neg_d = 1'b0;
            default: neg_d = (a_signed & A[Width-1]) ^ (b_signed & B[Width-1]);
          endcase
          divz_d  = in_div && (B == '0);
          ovf_d   = (in_funct inside {FnDiv, FnRem}) && (A == 32'h8000_0000) && (B == '1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        hi_d = hi_nxt;
        lo_d = lo_nxt;
        if (cnt_q == '0) begin
          out_d   = result;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (Flush) begin
      out_d   = '0;
      state_d = StIdle;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      funct_q <= FnMul;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

endmodule
